// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the start request and operands in, busy/done/result out.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, c_in, input busy, done, sum, c_out, ovf);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, ovf);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell evaluated per clock, LSB first, WIDTH cycles per result.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             carry_next;
  logic             sum_bit;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             last;
  logic             done_q;
  logic             c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single full-adder cell on the operand LSBs; the new sum bit enters at the MSB
  // so after WIDTH shifts the result register is fully aligned (works for WIDTH=1 too).
  always_comb begin
    sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    carry_next = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    res_next   = WIDTH'({sum_bit, res} >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= last;
      if (load) begin
        a_sr  <= bus.a;
        b_sr  <= bus.b;
        carry <= bus.c_in;
        cnt   <= '0;
        res   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        carry <= carry_next;
        res   <= res_next;
        if (!last) begin
          cnt <= cnt + CNT_W'(1);
        end
        if (last) begin
          sum_q   <= res_next;
          c_out_q <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_q   <= carry ^ carry_next;
`endif
        end
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
